top_block_code: RTL and testbench

TOP_BLOCK_CODE -- requirements
Module: top_block_code

---
 rtl/top_block_code.sv | 178 +++++++++++++++++
 tb/tb_top_block_code.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/top_block_code.sv
// Soft-decision maximum-likelihood decoder for the (20,A) block code.
// Stores one frame of symbols, scores every candidate message, then streams out the winner LSB first.
//
// state  | meaning
// -------+------------------------------------------------------------
// RECV   | accept NUM_SYMBOLS soft symbols; code length may be latched
// DECODE | score one candidate per cycle, highest index down to zero
// SEND   | emit A decoded bits, a(0) first, tlast on a(A-1)
module top_block_code #(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_SYMBOLS = 20
) (
    input  logic                  clk,
    input  logic                  s_axis_aresetn,
    input  logic [7:0]            code_length,
    input  logic                  code_length_valid,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic                  m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast
);

    localparam int MW = DATA_WIDTH + 5;
    localparam int CW = $clog2(NUM_SYMBOLS);

    // Row i holds M(i,0) in bit 12 down to M(i,12) in bit 0.
    localparam logic [12:0] M_ROM [20] = '{
        13'b1100000000110, 13'b1110000001110, 13'b1001001011111, 13'b1011000010111,
        13'b1111000100111, 13'b1100101110111, 13'b1010101011111, 13'b1001100110111,
        13'b1101100101111, 13'b1011101001111, 13'b1010011101111, 13'b1110011010111,
        13'b1001010111111, 13'b1101010101111, 13'b1000110100101, 13'b1100111101101,
        13'b1110111001011, 13'b1001110010011, 13'b1101111100000, 13'b1000011000000
    };

    typedef enum logic [1:0] {RECV, DECODE, SEND} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [3:0]             a_q, a_d;
    logic [12:0]            cand_q, cand_d;
    logic signed [MW-1:0]   best_q, best_d;
    logic [12:0]            best_idx_q, best_idx_d;
    logic [3:0]             idx_q, idx_d;
    logic signed [DATA_WIDTH-1:0] sym_q [NUM_SYMBOLS];
    logic                   sym_we;
    logic [3:0]             a_in;
    logic signed [MW-1:0]   metric_c;
    logic signed [MW-1:0]   ysx;
    logic                   cbit;
    logic                   unused_tlast;

    assign unused_tlast = s_axis_tlast;

    always_comb begin
        if (code_length == 8'd0) begin
            a_in = 4'd1;
        end else if (code_length > 8'd13) begin
            a_in = 4'd13;
        end else begin
            a_in = code_length[3:0];
        end
    end

    // Correlation of the stored symbols against the codeword of cand_q.
    always_comb begin
        metric_c = '0;
        ysx      = '0;
        cbit     = 1'b0;
        for (int i = 0; i < NUM_SYMBOLS; i++) begin
            cbit = 1'b0;
            for (int n = 0; n < 13; n++) begin
                cbit = cbit ^ (cand_q[n] & M_ROM[i][12-n]);
            end
            ysx = {{(MW-DATA_WIDTH){sym_q[i][DATA_WIDTH-1]}}, sym_q[i]};
            metric_c = cbit ? (metric_c - ysx) : (metric_c + ysx);
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        a_d           = a_q;
        cand_d        = cand_q;
        best_d        = best_q;
        best_idx_d    = best_idx_q;
        idx_d         = idx_q;
        sym_we        = 1'b0;
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = 1'b0;
        m_axis_tlast  = 1'b0;

        case (state_q)
            RECV: begin
                s_axis_tready = 1'b1;
                if ((cnt_q == '0) && code_length_valid) begin
                    a_d = a_in;
                end
                if (s_axis_tvalid) begin
                    sym_we = 1'b1;
                    if (cnt_q == CW'(NUM_SYMBOLS - 1)) begin
                        cnt_d   = '0;
                        state_d = DECODE;
                        cand_d  = (13'd1 << a_d) - 13'd1;
                        best_d  = {1'b1, {(MW-1){1'b0}}};
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DECODE: begin
                // Scanning downward with >= leaves the lowest index on ties.
                if (metric_c >= best_q) begin
                    best_d     = metric_c;
                    best_idx_d = cand_q;
                end
                if (cand_q == 13'd0) begin
                    state_d = SEND;
                    idx_d   = 4'd0;
                end else begin
                    cand_d = cand_q - 13'd1;
                end
            end
            SEND: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = best_idx_q[idx_q];
                m_axis_tlast  = (idx_q == a_q - 4'd1);
                if (m_axis_tready) begin
                    if (m_axis_tlast) begin
                        state_d = RECV;
                        cnt_d   = '0;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: state_d = RECV;
        endcase

        if (s_axis_aresetn) begin
            s_axis_tready = 1'b0;
            m_axis_tvalid = 1'b0;
            m_axis_tdata  = 1'b0;
            m_axis_tlast  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (s_axis_aresetn) begin
            state_q    <= RECV;
            cnt_q      <= '0;
            a_q        <= 4'd13;
            cand_q     <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            idx_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            cand_q     <= cand_d;
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            idx_q      <= idx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (sym_we) begin
            sym_q[cnt_q] <= s_axis_tdata;
        end
    end

endmodule

// File: tb/tb_top_block_code.sv
// Randomized/directed bench for top_block_code against a brute-force ML reference model.
module tb_top_block_code;
    localparam int DW = 8;
    localparam int NS = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    code_length;
    logic          clv;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid, s_tready, s_tlast;
    logic          m_tdata, m_tvalid, m_tready, m_tlast;

    int total = 0;
    int bad   = 0;
    int ys [NS];

    // Table rows written left to right as n = 0..12.
    bit [0:12] MT [20] = '{
        13'b1100000000110, 13'b1110000001110, 13'b1001001011111, 13'b1011000010111,
        13'b1111000100111, 13'b1100101110111, 13'b1010101011111, 13'b1001100110111,
        13'b1101100101111, 13'b1011101001111, 13'b1010011101111, 13'b1110011010111,
        13'b1001010111111, 13'b1101010101111, 13'b1000110100101, 13'b1100111101101,
        13'b1110111001011, 13'b1001110010011, 13'b1101111100000, 13'b1000011000000
    };

    always #5 clk = ~clk;

    top_block_code #(.DATA_WIDTH(DW), .NUM_SYMBOLS(NS)) dut (
        .clk               (clk),
        .s_axis_aresetn    (rst),
        .code_length       (code_length),
        .code_length_valid (clv),
        .s_axis_tdata      (s_tdata),
        .s_axis_tvalid     (s_tvalid),
        .s_axis_tready     (s_tready),
        .s_axis_tlast      (s_tlast),
        .m_axis_tdata      (m_tdata),
        .m_axis_tvalid     (m_tvalid),
        .m_axis_tready     (m_tready),
        .m_axis_tlast      (m_tlast)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int enc_bit(int msg, int a, int i);
        int c = 0;
        for (int n = 0; n < a; n++) c = c ^ (((msg >> n) & 1) & int'(MT[i][n]));
        return c;
    endfunction

    function automatic int ref_decode(int a, int y [NS]);
        int best = -1000000;
        int bk = 0;
        for (int k = 0; k < (1 << a); k++) begin
            int m = 0;
            for (int i = 0; i < NS; i++) m += (enc_bit(k, a, i) == 0) ? y[i] : -y[i];
            if (m > best) begin
                best = m;
                bk = k;
            end
        end
        return bk;
    endfunction

    task automatic gen_noisy(input int a, input int msg, input int amp, input int noise);
        for (int i = 0; i < NS; i++) begin
            int v = (enc_bit(msg, a, i) != 0) ? -amp : amp;
            if (noise > 0) v = v + int'($urandom_range(0, 2 * noise)) - noise;
            if (v > 127) v = 127;
            if (v < -128) v = -128;
            ys[i] = v;
        end
    endtask

    task automatic gen_const(input int v);
        for (int i = 0; i < NS; i++) ys[i] = v;
    endtask

    task automatic send_symbols(input bit gaps);
        for (int j = 0; j < NS; j++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                s_tvalid = 1'b0;
                step();
            end
            s_tdata  = ys[j][7:0];
            s_tvalid = 1'b1;
            s_tlast  = (j == NS - 1);
            if (j == 5) begin
                code_length = 8'd1;   // must be ignored: symbols already received
                clv = 1'b1;
            end
            step();
            clv = 1'b0;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic run_frame(input int a_cfg, input bit strobe, input int a_eff,
                             input bit bp, input bit gaps);
        int exp_k, lat, n, ph, cyc;
        logic prev_stall, pd, pl;
        exp_k = ref_decode(a_eff, ys);
        chk("rdy_recv", s_tready, 1);
        if (strobe) begin
            code_length = a_cfg[7:0];
            clv = 1'b1;
            step();
            clv = 1'b0;
        end
        send_symbols(gaps);
        chk("rdy_decode", s_tready, 0);
        lat = 0;
        while (!m_tvalid && lat <= (1 << a_eff) + 3) begin
            step();
            lat++;
        end
        chk("latency_ok", (lat <= (1 << a_eff) + 3) ? 1 : 0, 1);
        n = 0; ph = 0; cyc = 0;
        prev_stall = 1'b0; pd = 1'b0; pl = 1'b0;
        while (m_tvalid && n < a_eff && cyc < 2000) begin
            m_tready = bp ? ((ph % 30) < 10) : 1'b1;
            ph++;
            if (prev_stall) begin
                chk("stall_valid", m_tvalid, 1);
                chk("stall_data", m_tdata, pd);
                chk("stall_last", m_tlast, pl);
            end
            chk("excl", s_tready & m_tvalid, 0);
            if (m_tvalid && m_tready) begin
                chk("bit", m_tdata, (exp_k >> n) & 1);
                chk("tlast", m_tlast, (n == a_eff - 1) ? 1 : 0);
                n++;
            end
            prev_stall = m_tvalid & ~m_tready;
            pd = m_tdata;
            pl = m_tlast;
            step();
            cyc++;
        end
        m_tready = 1'b1;
        chk("beats", n, a_eff);
        chk("ret_rdy", s_tready, 1);
        chk("ret_valid", m_tvalid, 0);
        step();
        chk("no_extra", m_tvalid, 0);
    endtask

    initial begin
        int cnt_v;
        rst = 1'b1; code_length = 8'd0; clv = 1'b0;
        s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
        repeat (3) step();
        chk("rst_s_ready", s_tready, 0);
        chk("rst_m_valid", m_tvalid, 0);
        chk("rst_m_last", m_tlast, 0);
        chk("rst_m_data", m_tdata, 0);
        rst = 1'b0;
        step();
        chk("post_rst_ready", s_tready, 1);
        chk("post_rst_valid", m_tvalid, 0);

        // Default code length after reset is 13.
        gen_noisy(13, int'($urandom_range(0, 8191)), 64, 30);
        run_frame(0, 0, 13, 0, 0);

        gen_const(100);
        run_frame(5, 1, 5, 0, 0);

        gen_noisy(3, 5, 64, 0);
        run_frame(3, 1, 3, 0, 0);
        chk("dir_a3_model", ref_decode(3, ys), 5);

        gen_const(0);
        run_frame(4, 1, 4, 0, 0);

        gen_noisy(6, int'($urandom_range(0, 63)), 64, 50);
        run_frame(6, 1, 6, 0, 0);
        run_frame(6, 1, 6, 1, 0);

        gen_noisy(1, 1, 64, 40);
        run_frame(0, 1, 1, 0, 1);

        gen_noisy(13, int'($urandom_range(0, 8191)), 80, 60);
        run_frame(200, 1, 13, 1, 0);

        // Abort an A=7 frame mid-decode.
        gen_noisy(7, int'($urandom_range(0, 127)), 64, 30);
        code_length = 8'd7; clv = 1'b1;
        step();
        clv = 1'b0;
        send_symbols(0);
        repeat (20) step();
        chk("pre_abort_valid", m_tvalid, 0);
        rst = 1'b1;
        step();
        chk("abort_rst_ready", s_tready, 0);
        chk("abort_rst_valid", m_tvalid, 0);
        rst = 1'b0;
        step();
        chk("abort_rel_ready", s_tready, 1);
        cnt_v = 0;
        for (int c = 0; c < 200; c++) begin
            if (m_tvalid) cnt_v++;
            step();
        end
        chk("abort_no_output", cnt_v, 0);
        gen_noisy(2, int'($urandom_range(0, 3)), 64, 30);
        run_frame(2, 1, 2, 0, 0);

        for (int a = 2; a <= 7; a++) begin
            gen_noisy(a, int'($urandom_range(0, (1 << a) - 1)), 64, 70);
            run_frame(a, 1, a, (a % 2) == 1, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
